// File: rtl/ram_req_arbiter.sv
`default_nettype none
// ==================================================================
// Module  : ram_req_arbiter
// Brief   : round-robin two-requester front end that turns word
//           reads/writes into SPI RAM address/data command pairs
// Rev     : 1.0
// ==================================================================
module ram_req_arbiter #(
    parameter int MEM_DEPTH  = 256,
    parameter int RD_TIMEOUT = 4,
    localparam int ADDR_SIZE = $clog2(MEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 m0_req_valid,
    output logic                 m0_req_ready,
    input  logic                 m0_req_wr,
    input  logic [ADDR_SIZE-1:0] m0_req_addr,
    input  logic [ADDR_SIZE-1:0] m0_req_wdata,
    output logic                 m0_rsp_valid,
    output logic                 m0_rsp_err,
    input  logic                 m1_req_valid,
    output logic                 m1_req_ready,
    input  logic                 m1_req_wr,
    input  logic [ADDR_SIZE-1:0] m1_req_addr,
    input  logic [ADDR_SIZE-1:0] m1_req_wdata,
    output logic                 m1_rsp_valid,
    output logic                 m1_rsp_err,
    output logic [ADDR_SIZE-1:0] rsp_rdata,
    output logic                 rx_valid,
    output logic [ADDR_SIZE+1:0] rx_data,
    input  logic                 tx_valid,
    input  logic [ADDR_SIZE-1:0] tx_data,
    output logic                 busy
);

    localparam logic [1:0] c_CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] c_CMD_WR_DATA = 2'b01;
    localparam logic [1:0] c_CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] c_CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_WAIT = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_ptr;
    logic                  r_owner;
    logic                  r_wr;
    logic [ADDR_SIZE-1:0]  r_addr;
    logic [ADDR_SIZE-1:0]  r_wdata;
    logic [3:0]            r_cnt;
    logic                  r_err;
    logic [ADDR_SIZE-1:0]  r_rdata;
    logic                  r_rx_valid;
    logic [ADDR_SIZE+1:0]  r_rx_data;

    logic                  w_grant_valid;
    logic                  w_grant;
    logic                  w_timeout;
    logic                  w_sel_wr;
    logic [ADDR_SIZE-1:0]  w_sel_addr;
    logic [ADDR_SIZE-1:0]  w_sel_wdata;

    assign w_timeout   = (r_cnt == 4'(RD_TIMEOUT - 1));
    assign w_sel_wr    = w_grant ? m1_req_wr    : m0_req_wr;
    assign w_sel_addr  = w_grant ? m1_req_addr  : m0_req_addr;
    assign w_sel_wdata = w_grant ? m1_req_wdata : m0_req_wdata;

    always_comb begin
        w_next_state  = r_state;
        w_grant_valid = 1'b0;
        w_grant       = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (m0_req_valid && m1_req_valid) begin
                    w_grant_valid = 1'b1;
                    w_grant       = r_ptr;
                end else if (m0_req_valid) begin
                    w_grant_valid = 1'b1;
                    w_grant       = 1'b0;
                end else if (m1_req_valid) begin
                    w_grant_valid = 1'b1;
                    w_grant       = 1'b1;
                end
                if (w_grant_valid) begin
                    w_next_state = S_ADDR;
                end
            end
            S_ADDR:  w_next_state = S_DATA;
            S_DATA:  w_next_state = r_wr ? S_RESP : S_WAIT;
            S_WAIT: begin
                if (tx_valid || w_timeout) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Command bus is registered one state ahead so it lines up with ADDR/DATA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= 1'b0;
            r_owner    <= 1'b0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_valid) begin
                        r_owner    <= w_grant;
                        r_wr       <= w_sel_wr;
                        r_addr     <= w_sel_addr;
                        r_wdata    <= w_sel_wdata;
                        r_err      <= 1'b0;
                        r_rx_valid <= 1'b1;
                        r_rx_data  <= {(w_sel_wr ? c_CMD_WR_ADDR : c_CMD_RD_ADDR), w_sel_addr};
                    end
                end
                S_ADDR: begin
                    r_rx_data <= r_wr ? {c_CMD_WR_DATA, r_wdata}
                                      : {c_CMD_RD_DATA, {ADDR_SIZE{1'b0}}};
                end
                S_DATA: begin
                    r_rx_valid <= 1'b0;
                    r_rx_data  <= '0;
                    r_cnt      <= '0;
                end
                S_WAIT: begin
                    if (tx_valid) begin
                        r_rdata <= tx_data;
                        r_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_RESP:  r_ptr <= ~r_owner;
                default: ;
            endcase
        end
    end

    // Ready is gated by reset so every output reads 0 while rst_n is low.
    assign m0_req_ready = rst_n && w_grant_valid && !w_grant;
    assign m1_req_ready = rst_n && w_grant_valid &&  w_grant;
    assign m0_rsp_valid = (r_state == S_RESP) && !r_owner;
    assign m1_rsp_valid = (r_state == S_RESP) &&  r_owner;
    assign m0_rsp_err   = m0_rsp_valid && r_err;
    assign m1_rsp_err   = m1_rsp_valid && r_err;
    assign rsp_rdata    = r_rdata;
    assign rx_valid     = r_rx_valid;
    assign rx_data      = r_rx_data;
    assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ram_req_arbiter.sv
`default_nettype none
// ==================================================================
// Module  : tb_ram_req_arbiter
// Brief   : random two-requester traffic against a transaction model
// Rev     : 1.0
// ==================================================================
module tb_ram_req_arbiter;

    localparam int TO = 4;

    logic       clk;
    logic       rst_n;
    logic       m0_req_valid, m0_req_ready, m0_req_wr, m0_rsp_valid, m0_rsp_err;
    logic [7:0] m0_req_addr, m0_req_wdata;
    logic       m1_req_valid, m1_req_ready, m1_req_wr, m1_rsp_valid, m1_rsp_err;
    logic [7:0] m1_req_addr, m1_req_wdata;
    logic [7:0] rsp_rdata;
    logic       rx_valid;
    logic [9:0] rx_data;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       busy;

    ram_req_arbiter #(.MEM_DEPTH(256), .RD_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_wr(m0_req_wr),
        .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_err(m0_rsp_err),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_wr(m1_req_wr),
        .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_err(m1_rsp_err),
        .rsp_rdata(rsp_rdata), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Pending requests as each requester sees them
    logic       rq_v     [2];
    logic       rq_wr    [2];
    logic [7:0] rq_addr  [2];
    logic [7:0] rq_wdata [2];

    // Transaction-level model: t counts cycles since accept (0 = idle)
    int         t, resp_t, owner, ptr, tx_at, force_d;
    logic       cur_wr;
    logic [7:0] cur_addr, cur_wdata;
    logic [7:0] mem [256];
    logic [7:0] exp_rdata;
    bit         rand_on;

    task automatic new_req(input int i);
        rq_v[i]     = 1'b1;
        rq_wr[i]    = 1'($urandom_range(0, 1));
        rq_addr[i]  = 8'($urandom_range(0, 15));
        rq_wdata[i] = 8'($urandom);
    endtask

    task automatic accept(input int i);
        int r;
        t         = 1;
        owner     = i;
        cur_wr    = rq_wr[i];
        cur_addr  = rq_addr[i];
        cur_wdata = rq_wdata[i];
        rq_v[i]   = 1'b0;
        if (force_d >= 0) begin
            tx_at = force_d;
        end else begin
            r     = $urandom_range(0, 5);
            tx_at = (r == 0) ? 0 : (r == 1) ? $urandom_range(1, TO) : 1;
        end
        resp_t = cur_wr ? 3 : (tx_at != 0 ? 3 + tx_at : 3 + TO);
    endtask

    task automatic reset_check();
        chk("rst_ready",   {m1_req_ready, m0_req_ready}, 0);
        chk("rst_rsp",     {m1_rsp_valid, m1_rsp_err, m0_rsp_valid, m0_rsp_err}, 0);
        chk("rst_rx",      {rx_valid, rx_data}, 0);
        chk("rst_busy",    busy, 0);
        chk("rst_rdata",   rsp_rdata, 0);
    endtask

    task automatic step();
        logic [1:0] e_ready, e_rsp, e_err;
        logic [9:0] e_rx;
        logic       e_rxv;
        @(negedge clk);
        m0_req_valid = rq_v[0]; m0_req_wr = rq_wr[0]; m0_req_addr = rq_addr[0]; m0_req_wdata = rq_wdata[0];
        m1_req_valid = rq_v[1]; m1_req_wr = rq_wr[1]; m1_req_addr = rq_addr[1]; m1_req_wdata = rq_wdata[1];
        tx_data  = 8'($urandom);
        tx_valid = 1'b0;
        if (t != 0 && !cur_wr && tx_at != 0 && t == 2 + tx_at) begin
            tx_valid = 1'b1;
            tx_data  = mem[cur_addr];
        end else if (!(t >= 3 && t < resp_t) && $urandom_range(0, 3) == 0) begin
            tx_valid = 1'b1;   // stray data outside WAIT must be ignored
        end

        e_ready = 2'b00;
        if (t == 0) begin
            if (rq_v[0] && rq_v[1]) e_ready[ptr] = 1'b1;
            else if (rq_v[0])       e_ready[0]   = 1'b1;
            else if (rq_v[1])       e_ready[1]   = 1'b1;
        end
        e_rxv = (t == 1 || t == 2);
        e_rx  = (t == 1) ? {(cur_wr ? 2'b00 : 2'b10), cur_addr} :
                (t == 2) ? (cur_wr ? {2'b01, cur_wdata} : {2'b11, 8'h00}) : 10'h000;
        e_rsp = 2'b00;
        e_err = 2'b00;
        if (t != 0 && t == resp_t) begin
            e_rsp[owner] = 1'b1;
            e_err[owner] = !cur_wr && tx_at == 0;
            if (!cur_wr) exp_rdata = (tx_at != 0) ? mem[cur_addr] : 8'h00;
        end

        #1;
        chk("req_ready", {m1_req_ready, m0_req_ready}, e_ready);
        chk("busy",      busy, t != 0);
        chk("rx_valid",  rx_valid, e_rxv);
        chk("rx_data",   rx_data, e_rx);
        chk("rsp_valid", {m1_rsp_valid, m0_rsp_valid}, e_rsp);
        chk("rsp_err",   {m1_rsp_err, m0_rsp_err}, e_err);
        chk("rsp_rdata", rsp_rdata, exp_rdata);

        if (t == 0) begin
            if (e_ready[0] && rq_v[0])      accept(0);
            else if (e_ready[1] && rq_v[1]) accept(1);
        end else if (t == resp_t) begin
            if (cur_wr) mem[cur_addr] = cur_wdata;
            ptr = 1 - owner;
            t   = 0;
        end else begin
            t++;
        end
        if (rand_on) begin
            for (int i = 0; i < 2; i++)
                if (!rq_v[i] && $urandom_range(0, 1) == 0) new_req(i);
        end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0;
        m0_req_valid = 0; m0_req_wr = 0; m0_req_addr = 0; m0_req_wdata = 0;
        m1_req_valid = 0; m1_req_wr = 0; m1_req_addr = 0; m1_req_wdata = 0;
        tx_valid = 0; tx_data = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 2; i++) begin
            rq_v[i] = 0; rq_wr[i] = 0; rq_addr[i] = 0; rq_wdata[i] = 0;
        end
        t = 0; resp_t = 0; owner = 0; ptr = 0; tx_at = 0;
        cur_wr = 0; cur_addr = 0; cur_wdata = 0; exp_rdata = 0;
        rand_on = 0; force_d = 1;

        #3 reset_check();
        @(posedge clk); #2 rst_n = 1'b1;

        // m0 write 0x3C <= 0xA5, then m1 reads it back
        rq_v[0] = 1; rq_wr[0] = 1; rq_addr[0] = 8'h3C; rq_wdata[0] = 8'hA5;
        repeat (5) step();
        rq_v[1] = 1; rq_wr[1] = 0; rq_addr[1] = 8'h3C;
        repeat (6) step();

        // m0 read with the RAM silent: timeout path
        force_d = 0;
        rq_v[0] = 1; rq_wr[0] = 0; rq_addr[0] = 8'h10;
        repeat (TO + 5) step();

        // Random contention
        force_d = -1;
        rand_on = 1;
        repeat (3000) step();

        rand_on = 0;
        for (int k = 0; k < 200 && !(t == 0 && !rq_v[0] && !rq_v[1]); k++) step();

        // m1 write interrupted by reset during its DATA cycle
        rq_v[1] = 1; rq_wr[1] = 1; rq_addr[1] = 8'h20; rq_wdata[1] = 8'h5A;
        step();
        step();
        @(negedge clk);
        m0_req_valid = 1'b1;
        m1_req_valid = 1'b1;
        rst_n = 1'b0;
        #1 reset_check();
        t = 0; ptr = 0; exp_rdata = 8'h00;
        rq_v[0] = 1; rq_wr[0] = 0; rq_addr[0] = 8'h10; rq_wdata[0] = 8'h00;
        rq_v[1] = 1; rq_wr[1] = 1; rq_addr[1] = 8'h21; rq_wdata[1] = 8'hC3;
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (20) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
